// File: rtl/instr_stream_loader.sv
// Instruction loader: assembles UART words/bytes, buffers them in a FIFO
// and issues single-cycle writes into instruction memory.
module instr_stream_loader #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int BYTE_MODE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_data_received,
  input  logic [XLEN-1:0]   i_data,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_mem_ready,
  output logic              o_write_enable,
  output logic [ADDR_W-1:0] o_address,
  output logic [XLEN-1:0]   o_instruction,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_words_loaded,
  output logic              o_debug_flag
);

  localparam int NB = XLEN / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic [XLEN-1:0]   push_word;
  logic [XLEN-1:0]   fifo_q [FIFO_DEPTH];
  logic [FW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [0:0]        state_q, state_d;
  logic              ovf_q, ovf_d, dbg_q, dbg_d;
  logic              word_done, push_ok;
  logic              empty, full, pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[FW] != rd_q[FW]) &&
                 (wr_q[FW-1:0] == rd_q[FW-1:0]);
  // No bypass: a word pushed this cycle is popped next cycle at the earliest.
  assign pop   = !i_clear && !empty && i_mem_ready;

  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    push_word = i_data;
    word_done = 1'b0;
    if (BYTE_MODE != 0) begin
      push_word = asm_q;
      push_word[cnt_q*8 +: 8] = i_data[7:0];
      if (i_data_received) begin
        if (cnt_q == CW'(NB - 1)) begin
          word_done = 1'b1;
          cnt_d     = '0;
          asm_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          asm_d = push_word;
        end
      end
    end else begin
      word_done = i_data_received;
    end
    if (i_clear) begin
      cnt_d     = '0;
      asm_d     = '0;
      word_done = 1'b0;
    end
  end

  assign push_ok = word_done && (!full || pop);

  always_comb begin
    wr_d    = push_ok ? wr_q + (FW+1)'(1) : wr_q;
    rd_d    = pop ? rd_q + (FW+1)'(1) : rd_q;
    state_d = pop ? WRITE : IDLE;
    addr_d  = addr_q;
    instr_d = instr_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    if (pop) begin
      addr_d  = ptr_q;
      instr_d = fifo_q[rd_q[FW-1:0]];
      ptr_d   = ptr_q + ADDR_W'(1);
      if (words_q != '1) words_d = words_q + (ADDR_W+1)'(1);
    end
    ovf_d = ovf_q || (word_done && full && !pop);
    dbg_d = push_ok;
    if (i_clear) begin
      wr_d    = '0;
      rd_d    = '0;
      ptr_d   = i_start_addr;
      words_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_q[FW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      words_q <= '0;
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      dbg_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      words_q <= words_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      dbg_q   <= dbg_d;
    end
  end

  assign o_write_enable = (state_q == WRITE);
  assign o_address      = addr_q;
  assign o_instruction  = instr_q;
  assign o_busy         = !empty || (cnt_q != '0);
  assign o_overflow     = ovf_q;
  assign o_words_loaded = words_q;
  assign o_debug_flag   = dbg_q;

endmodule

// File: doc/instr_stream_loader.md
# instr_stream_loader

Parametrised instruction loader that turns a stream of received words or bytes (UART side) into single-cycle writes into the instruction memory owned by `instructionFetch`. It replaces the fixed 32-bit, unbuffered `instructionLoad` with four additions: byte-assembly mode, an input FIFO with backpressure from the fetch stage, a configurable start address with wrap-around, and sticky overflow reporting.

## Interface
Parameters:
- `XLEN`, default 32: instruction width; must be a multiple of 8.
- `ADDR_W`, default 3: instruction memory address width; memory depth is 2^ADDR_W.
- `FIFO_DEPTH`, default 4: input buffer depth; power of 2, ≥ 2.
- `BYTE_MODE`, default 1:
  - 1 = input is bytes on `i_data[7:0]`, assembled little-endian.
  - 0 = input is whole words on `i_data`.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_data_received`  in  1  one-cycle strobe; `i_data` is valid in that cycle.
- `i_data`  in  XLEN  incoming word, or byte in `[7:0]` when BYTE_MODE=1.
- `i_clear`  in  1  synchronous restart of a load session.
- `i_start_addr`  in  ADDR_W  address of the first write; sampled on `i_clear`.
- `i_mem_ready`  in  1  fetch stage can accept a write this cycle.
- `o_write_enable`  out  1  one-cycle memory write strobe.
- `o_address`  out  ADDR_W  write address; valid while `o_write_enable` is high.
- `o_instruction`  out  XLEN  write data; valid while `o_write_enable` is high.
- `o_busy`  out  1  FIFO non-empty, or a partial word is being assembled.
- `o_overflow`  out  1  sticky: a word was dropped.
- `o_words_loaded`  out  ADDR_W+1  count of completed writes; saturates at all-ones.
- `o_debug_flag`  out  1  high for one cycle on each FIFO push.

## Operation
**Assembler**
- BYTE_MODE=1:
  - Byte counter runs 0..XLEN/8-1. Byte k goes to bits `[8k+7:8k]`.
  - On the strobe carrying the last byte, the assembled word is pushed and the counter returns to 0.
- BYTE_MODE=0: every strobe pushes `i_data` directly.

**FIFO**
- FIFO_DEPTH entries, with read and write pointers one bit wider than the index, for full/empty detection.
- A push when full is accepted only if a pop happens in the same cycle. Otherwise the word is dropped and `o_overflow` is set.

**Writer FSM**
- States: IDLE (`o_write_enable`=0) and WRITE (`o_write_enable`=1 for exactly one cycle).
- IDLE→WRITE when the FIFO is non-empty and `i_mem_ready`=1. The head is popped into `o_instruction`, and `o_address` is set to the current address pointer.
- WRITE→WRITE when the same condition holds again; back-to-back writes are allowed at one per cycle. Otherwise WRITE→IDLE.
- The address pointer increments after each write and wraps from 2^ADDR_W-1 to 0.
- `o_words_loaded` increments on each write.

**i_clear**
- Empties the FIFO and zeroes the byte counter and `o_words_loaded`.
- Clears `o_overflow`.
- Loads the address pointer from `i_start_addr`.
- Forces IDLE.
- Has priority over a strobe in the same cycle; that strobe is ignored.

## Timing
**Reset values:** all outputs are 0. Address pointer 0, FIFO empty, byte counter 0, FSM in IDLE.

**Latency** (with `i_mem_ready`=1 and FIFO empty):
- Strobe completing a word in cycle 0 → push at the end of cycle 0 → `o_write_enable` high in cycle 2.
- `o_debug_flag` is high in cycle 1.

**Backpressure**
- `i_mem_ready` is sampled combinationally in the pop decision. While it is low, no pop occurs and `o_write_enable` is 0 in the following cycle.
- Data is never lost under backpressure unless the FIFO is full.

**Boundary conditions**
- Empty FIFO with a push in the same cycle: no pop that cycle; the pop happens next cycle (no bypass).
- Full FIFO with push and pop in the same cycle: both take effect, and occupancy stays FIFO_DEPTH.
- Overflow: the dropped word is lost, FIFO contents are unchanged, and `o_overflow` stays 1 until `i_clear` or `rst`.
- Address wrap: the write after address 2^ADDR_W-1 goes to 0, with no flag.
- `o_words_loaded` holds at 2^(ADDR_W+1)-1.
- Partial word with no further strobes: held indefinitely and `o_busy` stays 1. Only `i_clear` discards it.
- `rst` mid-write: `o_write_enable` drops immediately (asynchronous), and all state returns to reset values.

## Test plan
- **Word mode** (BYTE_MODE=0), `i_start_addr`=0 via `i_clear`: strobe 0x00210233 → `o_write_enable` in cycle 2 with address 0 and data 0x00210233. `o_words_loaded`=1.
- **Byte mode**: bytes 0x13,0x85,0x20,0x00 on four strobes → one write of 0x00208513 at address 0. No write occurs after the first three bytes, and `o_busy`=1 meanwhile.
- **Backpressure**: `i_mem_ready`=0, push 3 words → no writes. Raise `i_mem_ready` → three consecutive single-cycle writes in order, at addresses 0,1,2.
- **Overflow**: `i_mem_ready`=0, push 5 words with FIFO_DEPTH=4 → `o_overflow`=1. Release → exactly words 1–4 are written. Then `i_clear` → `o_overflow`=0.
- **Wrap**: ADDR_W=3, `i_start_addr`=6, push 3 words → writes at 6, 7, 0.
- **Reset/clear**: assert `rst` during a write burst → all outputs 0 immediately. `i_clear` coincident with the final byte strobe → no write occurs, and the counter restarts at byte 0.
